// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle of the hazard stall controller.
// master: the pipeline raising hazards; slave: the controller answering them.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             MCycleStartE;
    logic             MCycleBusy;
    logic             MemReqM;
    logic             MemReadyM;
    logic             MemtoRegE;
    logic [4:0]       rdE;
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic             PCSrcE;
    logic             ClearCount;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output MCycleStartE,
        output MCycleBusy,
        output MemReqM,
        output MemReadyM,
        output MemtoRegE,
        output rdE,
        output rs1D,
        output rs2D,
        output PCSrcE,
        output ClearCount,
        input  StallF,
        input  StallD,
        input  StallE,
        input  StallM,
        input  FlushD,
        input  FlushE,
        input  FlushW,
        input  MemTimeout,
        input  StallCount
    );

    modport slave (
        input  MCycleStartE,
        input  MCycleBusy,
        input  MemReqM,
        input  MemReadyM,
        input  MemtoRegE,
        input  rdE,
        input  rs1D,
        input  rs2D,
        input  PCSrcE,
        input  ClearCount,
        output StallF,
        output StallD,
        output StallE,
        output StallM,
        output FlushD,
        output FlushE,
        output FlushW,
        output MemTimeout,
        output StallCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates memory wait, MUL/DIV, load-use and branch hazards.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    hazard_stall_controller_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        MEMWAIT,
        MCYCLE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic [CNT_W-1:0]  stallCnt;
    logic              memTimeoutQ;

    logic memMiss;
    logic loadUse;
    logic hold;
    logic luStall;
    logic brFlush;
    logic timeoutHit;

    logic stallFront;
    logic stallBack;
    logic flushDec;
    logic flushExe;
    logic bubbleWb;

    // Raw hazard detection from the pipeline stage contents.
    always_comb begin
        memMiss = hz.MemReqM && !hz.MemReadyM;
        loadUse = hz.MemtoRegE
               && (hz.rdE != 5'd0)
               && ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    end

    // Next state and arbitrated stall cause; a release cycle
    // behaves like IDLE for the causes younger than the one released.
    always_comb begin
        logic evalMem;
        logic evalMul;
        logic evalHaz;
        stateNext   = state;
        waitCntNext = waitCnt;
        hold        = 1'b0;
        luStall     = 1'b0;
        brFlush     = 1'b0;
        timeoutHit  = 1'b0;
        evalMem     = 1'b0;
        evalMul     = 1'b0;
        evalHaz     = 1'b0;

        unique case (state)
            IDLE: begin
                evalMem = 1'b1;
                evalMul = 1'b1;
                evalHaz = 1'b1;
            end
            MEMWAIT: begin
                if (hz.MemReadyM) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                    evalMul     = 1'b1;
                    evalHaz     = 1'b1;
                end else if (waitCnt == WAIT_MAX) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                    timeoutHit  = 1'b1;
                end else begin
                    hold        = 1'b1;
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            MCYCLE: begin
                if (hz.MCycleBusy) begin
                    hold = 1'b1;
                end else begin
                    stateNext = IDLE;
                    evalHaz   = 1'b1;
                end
            end
            default: begin
                stateNext   = IDLE;
                waitCntNext = '0;
            end
        endcase

        if (evalMem && memMiss) begin
            hold        = 1'b1;
            stateNext   = MEMWAIT;
            waitCntNext = WAIT_W'(1);
        end else if (evalMul && hz.MCycleStartE) begin
            hold      = 1'b1;
            stateNext = MCYCLE;
        end else if (evalHaz && loadUse) begin
            luStall = 1'b1;
        end else if (evalHaz && hz.PCSrcE) begin
            brFlush = 1'b1;
        end
    end

    // Stage controls; stalls mask flushes and reset forces all low.
    always_comb begin
        stallFront = 1'b0;
        stallBack  = 1'b0;
        flushDec   = 1'b0;
        flushExe   = 1'b0;
        bubbleWb   = 1'b0;
        if (RESETn) begin
            stallFront = hold || luStall;
            stallBack  = hold;
            bubbleWb   = hold;
            flushDec   = brFlush && !hold;
            flushExe   = (brFlush || luStall) && !hold;
        end
    end

    // Sequencer state and memory wait counter.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Sticky flag for an abandoned memory access.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            memTimeoutQ <= 1'b0;
        end else if (timeoutHit) begin
            memTimeoutQ <= 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles; clear has priority.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stallCnt <= '0;
        end else if (hz.ClearCount) begin
            stallCnt <= '0;
        end else if (stallFront && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign hz.StallF     = stallFront;
    assign hz.StallD     = stallFront;
    assign hz.StallE     = stallBack;
    assign hz.StallM     = stallBack;
    assign hz.FlushD     = flushDec;
    assign hz.FlushE     = flushExe;
    assign hz.FlushW     = bubbleWb;
    assign hz.MemTimeout = memTimeoutQ;
    assign hz.StallCount = stallCnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_hazard_stall_controller;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    hazard_stall_controller_if #(.CNT_W(CW)) hzIf();

    hazard_stall_controller #(
        .MEM_TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .hz(hzIf)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] flags;
        bit         nMem;
        bit         nMul;
        int         nWait;
        bit         nTo;
    } res_t;

    // Model state: what the pipeline is currently waiting on.
    bit mMemPending = 1'b0;
    bit mMulPending = 1'b0;
    int mWaited     = 0;
    bit mTo         = 1'b0;
    int mCnt        = 0;
    res_t ce;
    res_t ue;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs {F,D,E,M,FD,FE,FW} and model successor.
    function automatic res_t model_eval();
        res_t r;
        bit freeze;
        bit lu;
        bit br;
        bit memOk;
        bit mulOk;
        bit hazOk;
        freeze = 0; lu = 0; br = 0;
        memOk = 0; mulOk = 0; hazOk = 0;
        r.flags = '0; r.nMem = 0; r.nMul = 0; r.nWait = 0; r.nTo = 0;
        if (!RESETn) return r;
        if (mMemPending) begin
            if (hzIf.MemReadyM) begin
                mulOk = 1; hazOk = 1;
            end else if (mWaited >= TO) begin
                r.nTo = 1;
            end else begin
                freeze = 1; r.nMem = 1; r.nWait = mWaited + 1;
            end
        end else if (mMulPending) begin
            if (hzIf.MCycleBusy) begin
                freeze = 1; r.nMul = 1;
            end else begin
                hazOk = 1;
            end
        end else begin
            memOk = 1; mulOk = 1; hazOk = 1;
        end
        if (memOk && hzIf.MemReqM && !hzIf.MemReadyM) begin
            freeze = 1; r.nMem = 1; r.nWait = 1;
        end else if (mulOk && hzIf.MCycleStartE) begin
            freeze = 1; r.nMul = 1;
        end else if (hazOk && hzIf.MemtoRegE && hzIf.rdE != 0
                     && (hzIf.rdE == hzIf.rs1D || hzIf.rdE == hzIf.rs2D)) begin
            lu = 1;
        end else if (hazOk && hzIf.PCSrcE) begin
            br = 1;
        end
        r.flags = {freeze | lu, freeze | lu, freeze, freeze,
                   br & ~freeze, (br | lu) & ~freeze, freeze};
        return r;
    endfunction

    // Advance the model on each clock, reset asynchronously.
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mMemPending = 0; mMulPending = 0; mWaited = 0;
            mTo = 0; mCnt = 0;
        end else begin
            ue = model_eval();
            if (hzIf.ClearCount) mCnt = 0;
            else if (ue.flags[6] && mCnt < CMAX) mCnt = mCnt + 1;
            mMemPending = ue.nMem;
            mMulPending = ue.nMul;
            mWaited     = ue.nWait;
            if (ue.nTo) mTo = 1;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge CLK) begin
        ce = model_eval();
        chk("flags FDEM_FD_FE_FW",
            32'({hzIf.StallF, hzIf.StallD, hzIf.StallE, hzIf.StallM,
                 hzIf.FlushD, hzIf.FlushE, hzIf.FlushW}),
            32'(ce.flags));
        chk("StallCount", 32'(hzIf.StallCount), mCnt);
        chk("MemTimeout", 32'(hzIf.MemTimeout), 32'(mTo));
    end

    task automatic idle_ins();
        hzIf.MCycleStartE = 0; hzIf.MCycleBusy = 0;
        hzIf.MemReqM = 0; hzIf.MemReadyM = 0;
        hzIf.MemtoRegE = 0; hzIf.rdE = 0;
        hzIf.rs1D = 0; hzIf.rs2D = 0;
        hzIf.PCSrcE = 0; hzIf.ClearCount = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle_ins();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset StallCount", 32'(hzIf.StallCount), 32'd0);
        chk("reset MemTimeout", 32'(hzIf.MemTimeout), 32'd0);
        chk("reset StallF", 32'(hzIf.StallF), 32'd0);
        RESETn = 1;
        tick();

        // T1 load-use
        hzIf.MemtoRegE = 1; hzIf.rdE = 5; hzIf.rs1D = 5;
        #3;
        chk("T1 StallF", 32'(hzIf.StallF), 32'd1);
        chk("T1 FlushE", 32'(hzIf.FlushE), 32'd1);
        chk("T1 StallE", 32'(hzIf.StallE), 32'd0);
        tick(); idle_ins();
        #3;
        chk("T1 one cycle", 32'(hzIf.StallF), 32'd0);
        chk("T1 count", 32'(hzIf.StallCount), 32'd1);
        tick(); hzIf.MemtoRegE = 1; hzIf.rdE = 7; hzIf.rs2D = 7;
        #3;
        chk("T1 rs2 StallD", 32'(hzIf.StallD), 32'd1);
        tick(); idle_ins(); hzIf.MemtoRegE = 1;
        #3;
        chk("T1 x0 StallF", 32'(hzIf.StallF), 32'd0);
        tick(); idle_ins(); hzIf.PCSrcE = 1;
        #3;
        chk("branch FlushD", 32'(hzIf.FlushD), 32'd1);
        tick(); idle_ins(); hzIf.ClearCount = 1;
        tick(); idle_ins();
        #3;
        chk("clear count", 32'(hzIf.StallCount), 32'd0);

        // T2 three wait states
        tick(); hzIf.MemReqM = 1;
        tick(); tick();
        #3;
        chk("T2 FlushW", 32'(hzIf.FlushW), 32'd1);
        tick(); hzIf.MemReadyM = 1;
        #3;
        chk("T2 release StallM", 32'(hzIf.StallM), 32'd0);
        chk("T2 release FlushW", 32'(hzIf.FlushW), 32'd0);
        tick(); idle_ins();
        #3;
        chk("T2 count", 32'(hzIf.StallCount), 32'd3);
        hzIf.ClearCount = 1;

        // T3 timeout
        tick(); idle_ins(); hzIf.MemReqM = 1;
        repeat (3) tick();
        tick();
        #3;
        chk("T3 release", 32'(hzIf.StallF), 32'd0);
        tick(); idle_ins();
        #3;
        chk("T3 MemTimeout", 32'(hzIf.MemTimeout), 32'd1);
        chk("T3 count", 32'(hzIf.StallCount), 32'd4);

        // T4 memory wait then MUL/DIV, no gap
        tick(); hzIf.MCycleStartE = 1; hzIf.MemReqM = 1;
        tick();
        tick(); hzIf.MemReadyM = 1;
        #3;
        chk("T4 no gap", 32'(hzIf.StallM), 32'd1);
        tick(); hzIf.MemReqM = 0; hzIf.MemReadyM = 0; hzIf.MCycleBusy = 1;
        repeat (4) tick();
        tick(); hzIf.MCycleBusy = 0;
        #3;
        chk("T4 release", 32'(hzIf.StallF), 32'd0);
        tick(); idle_ins();
        #3;
        chk("T4 count", 32'(hzIf.StallCount), 32'd12);

        // T5 branch under MUL/DIV stall
        tick(); hzIf.MCycleStartE = 1;
        tick(); hzIf.MCycleBusy = 1; hzIf.PCSrcE = 1;
        #3;
        chk("T5 FlushD masked", 32'(hzIf.FlushD), 32'd0);
        chk("T5 FlushE masked", 32'(hzIf.FlushE), 32'd0);
        tick(); tick();
        tick(); hzIf.MCycleBusy = 0;
        #3;
        chk("T5 FlushD release", 32'(hzIf.FlushD), 32'd1);
        chk("T5 FlushE release", 32'(hzIf.FlushE), 32'd1);
        tick(); idle_ins();
        #3;
        chk("saturated", 32'(hzIf.StallCount), 32'd15);
        tick(); hzIf.MemtoRegE = 1; hzIf.rdE = 3; hzIf.rs1D = 3;
        tick(); idle_ins();
        #3;
        chk("saturation holds", 32'(hzIf.StallCount), 32'd15);

        // T6 async reset in MEMWAIT
        tick(); hzIf.MemReqM = 1;
        tick();
        #1;
        chk("T6 pre-reset StallM", 32'(hzIf.StallM), 32'd1);
        #1;
        RESETn = 0;
        #1;
        chk("T6 StallF", 32'(hzIf.StallF), 32'd0);
        chk("T6 StallM", 32'(hzIf.StallM), 32'd0);
        chk("T6 FlushW", 32'(hzIf.FlushW), 32'd0);
        chk("T6 StallCount", 32'(hzIf.StallCount), 32'd0);
        chk("T6 MemTimeout", 32'(hzIf.MemTimeout), 32'd0);
        idle_ins();
        tick(); RESETn = 1;
        tick();
        #3;
        chk("T6 idle after", 32'(hzIf.StallF), 32'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule
